// File: rtl/yarp_pkg.sv
// Shared types for the YARP multi-cycle core: opcodes, controller states and mux selects.
package yarp_pkg;

    typedef enum logic [6:0] {
        OP_R      = 7'h33,
        OP_I      = 7'h13,
        OP_LOAD   = 7'h03,
        OP_STORE  = 7'h23,
        OP_BRANCH = 7'h63,
        OP_LUI    = 7'h37,
        OP_AUIPC  = 7'h17,
        OP_JAL    = 7'h6F,
        OP_JALR   = 7'h67
    } riscv_op_e;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_WAIT_I,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WAIT_D,
        ST_WB,
        ST_TRAP
    } ctrl_state_e;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_BR_JAL = 2'd1,
        PC_JALR   = 2'd2
    } pc_sel_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_IMM = 2'd3
    } wb_sel_e;

    function automatic logic is_legal_op(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: is_legal_op = 1'b1;
            default:                           is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/yarp_mc_ctrl.sv
// Multi-cycle instruction sequencer for YARP: fetch/decode/execute/memory/writeback
// control, sticky illegal-opcode trap and retired-instruction counter.
//
// state  | meaning
// FETCH  | issue one-cycle instruction fetch request
// WAIT_I | wait for instruction response, capture IR
// DECODE | classify opcode, legal -> EXEC, else TRAP
// EXEC   | branches retire here; loads/stores -> MEM; others -> WB
// MEM    | issue one-cycle data request
// WAIT_D | wait for data ack; stores retire here, loads -> WB
// WB     | register write and PC update
// TRAP   | illegal opcode; frozen until reset
module yarp_mc_ctrl
    import yarp_pkg::*;
(
    input  logic        clk,
    input  logic        reset_i,
    input  logic [6:0]  op_i,
    input  logic        branch_taken_i,
    input  logic        imem_rvalid_i,
    input  logic        dmem_rvalid_i,
    output logic        imem_req_o,
    output logic        ir_we_o,
    output logic        dmem_req_o,
    output logic        dmem_wr_o,
    output logic        rf_we_o,
    output logic [1:0]  wb_sel_o,
    output logic        pc_we_o,
    output logic [1:0]  pc_sel_o,
    output logic        illegal_o,
    output logic [31:0] instret_o
);

    ctrl_state_e state, state_nxt;
    logic [31:0] instret_q;

    logic    imem_req, ir_we, dmem_req, dmem_wr, rf_we, pc_we, illegal;
    wb_sel_e wb_sel;
    pc_sel_e pc_sel;

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state     <= ST_FETCH;
            instret_q <= '0;
        end else begin
            state <= state_nxt;
            if (pc_we) begin
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        dmem_req  = 1'b0;
        dmem_wr   = 1'b0;
        rf_we     = 1'b0;
        pc_we     = 1'b0;
        illegal   = 1'b0;
        wb_sel    = WB_ALU;
        pc_sel    = PC_PLUS4;
        case (state)
            ST_FETCH: begin
                imem_req  = 1'b1;
                state_nxt = ST_WAIT_I;
            end
            ST_WAIT_I: begin
                if (imem_rvalid_i) begin
                    ir_we     = 1'b1;
                    state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_nxt = is_legal_op(op_i) ? ST_EXEC : ST_TRAP;
            end
            ST_EXEC: begin
                if (op_i == OP_BRANCH) begin
                    pc_we     = 1'b1;
                    pc_sel    = branch_taken_i ? PC_BR_JAL : PC_PLUS4;
                    state_nxt = ST_FETCH;
                end else if (op_i == OP_LOAD || op_i == OP_STORE) begin
                    state_nxt = ST_MEM;
                end else begin
                    state_nxt = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_req  = 1'b1;
                dmem_wr   = (op_i == OP_STORE);
                state_nxt = ST_WAIT_D;
            end
            ST_WAIT_D: begin
                if (dmem_rvalid_i) begin
                    if (op_i == OP_STORE) begin
                        pc_we     = 1'b1;
                        state_nxt = ST_FETCH;
                    end else begin
                        state_nxt = ST_WB;
                    end
                end
            end
            ST_WB: begin
                rf_we     = 1'b1;
                pc_we     = 1'b1;
                state_nxt = ST_FETCH;
                case (op_i)
                    OP_LOAD:         wb_sel = WB_MEM;
                    OP_JAL, OP_JALR: wb_sel = WB_PC4;
                    OP_LUI:          wb_sel = WB_IMM;
                    default:         wb_sel = WB_ALU;
                endcase
                case (op_i)
                    OP_JAL:  pc_sel = PC_BR_JAL;
                    OP_JALR: pc_sel = PC_JALR;
                    default: pc_sel = PC_PLUS4;
                endcase
            end
            ST_TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                state_nxt = ST_FETCH;
            end
        endcase
    end

    // Reset masks every strobe combinationally so nothing leaks in the reset cycle itself.
    assign imem_req_o = imem_req & ~reset_i;
    assign ir_we_o    = ir_we    & ~reset_i;
    assign dmem_req_o = dmem_req & ~reset_i;
    assign dmem_wr_o  = dmem_wr  & ~reset_i;
    assign rf_we_o    = rf_we    & ~reset_i;
    assign pc_we_o    = pc_we    & ~reset_i;
    assign illegal_o  = illegal  & ~reset_i;
    assign wb_sel_o   = reset_i ? 2'd0 : wb_sel;
    assign pc_sel_o   = reset_i ? 2'd0 : pc_sel;
    assign instret_o  = instret_q;

endmodule
